// File: rtl/fft_pkg.sv
// Shared FFT-chain constants and types (FFT source, peak picker, threshold).
package fft_pkg;

  localparam int unsigned FFT      = 1024;
  localparam int unsigned LGFFT    = 10;
  localparam int unsigned HFFT     = FFT / 2;
  localparam int unsigned DW       = 16;
  localparam int unsigned MAGFLOOR = 64;

  typedef logic [LGFFT-2:0]        bin_t;
  typedef logic [LGFFT-1:0]        cnt_t;
  typedef logic [DW:0]             mag_t;
  typedef logic [DW-1:0]           umag_t;
  typedef logic signed [DW-1:0]    sample_t;

  // Two's-complement magnitude; -2^(DW-1) maps to 2^(DW-1), which fits unsigned DW bits.
  function automatic umag_t abs_sample(input sample_t s);
    umag_t u;
    u = umag_t'(s);
    return s[DW-1] ? ((~u) + umag_t'(1)) : u;
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Two-stage magnitude approximation (abs, then |re|+|im| or alpha-max-beta-min).
// Build option: define PEAK_MAG_AMBM_EN for mag = max + min/4 + min/8.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [LGFFT-1:0]     i_bin,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic                 o_valid,
  output logic [LGFFT-1:0]     o_bin,
  output logic [DW:0]          o_mag
);

  logic  s1_valid;
  cnt_t  s1_bin;
  umag_t abs_re_q;
  umag_t abs_im_q;
  mag_t  mag_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      abs_re_q <= '0;
      abs_im_q <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_bin   <= i_bin;
      abs_re_q <= abs_sample(i_re);
      abs_im_q <= abs_sample(i_im);
    end
  end

`ifdef PEAK_MAG_AMBM_EN
  umag_t mx;
  umag_t mn;

  always_comb begin
    mx = '0;
    mn = '0;
    if (abs_re_q >= abs_im_q) begin
      mx = abs_re_q;
      mn = abs_im_q;
    end else begin
      mx = abs_im_q;
      mn = abs_re_q;
    end
    mag_d = mag_t'(mx) + mag_t'(mn >> 2) + mag_t'(mn >> 3);
  end
`else
  always_comb begin
    mag_d = mag_t'(abs_re_q) + mag_t'(abs_im_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_bin   <= '0;
      o_mag   <= '0;
    end else begin
      o_valid <= s1_valid;
      o_bin   <= s1_bin;
      o_mag   <= mag_d;
    end
  end

endmodule

// File: rtl/fft_peak_picker.sv
// Tracks the strongest positive-frequency bin (DC excluded) per frame and publishes its index.
// Build option: PEAK_MAG_AMBM_EN selects the magnitude approximation in fft_mag_approx.
module fft_peak_picker
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_sop,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic [LGFFT-2:0]     o_index,
  output logic [DW:0]          o_mag,
  output logic                 o_valid
);

  localparam cnt_t LastBin  = cnt_t'(FFT - 1);
  localparam cnt_t HalfBin  = cnt_t'(HFFT);
  localparam mag_t MagFloor = mag_t'(MAGFLOOR);

  cnt_t cnt_q;
  cnt_t bin_in;

  logic s2_valid;
  cnt_t s2_bin;
  mag_t s2_mag;

  mag_t max_q, max_d;
  bin_t best_q, best_d;
  logic done_q, done_d;

  // An sop beat is bin 0 whatever the counter says, which also resyncs a broken frame.
  assign bin_in = i_sop ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_valid) begin
      cnt_q <= bin_in + cnt_t'(1);
    end
  end

  fft_mag_approx u_mag (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_bin   (bin_in),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_valid (s2_valid),
    .o_bin   (s2_bin),
    .o_mag   (s2_mag)
  );

  always_comb begin
    max_d  = max_q;
    best_d = best_q;
    done_d = 1'b0;
    if (done_q) begin
      max_d  = '0;
      best_d = '0;
    end
    if (s2_valid) begin
      // Bin 0 starts a frame (normal or resync), so the running max restarts here.
      if (s2_bin == '0) begin
        max_d  = '0;
        best_d = '0;
      end else if ((s2_bin < HalfBin) && (s2_mag > max_d)) begin
        max_d  = s2_mag;
        best_d = s2_bin[LGFFT-2:0];
      end
      done_d = (s2_bin == LastBin);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q  <= '0;
      best_q <= '0;
      done_q <= 1'b0;
    end else begin
      max_q  <= max_d;
      best_q <= best_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_index <= '0;
      o_mag   <= '0;
    end else begin
      o_valid <= done_q;
      if (done_q) begin
        o_mag   <= max_q;
        o_index <= (max_q >= MagFloor) ? best_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_picker.sv
// Randomized bench for fft_peak_picker against a per-frame reference model.
module tb_fft_peak_picker;
  import fft_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic                 i_sop;
  logic signed [DW-1:0] i_re;
  logic signed [DW-1:0] i_im;
  logic [LGFFT-2:0]     o_index;
  logic [DW:0]          o_mag;
  logic                 o_valid;

  fft_peak_picker dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_sop   (i_sop),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_index (o_index),
    .o_mag   (o_mag),
    .o_valid (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  int fre [FFT];
  int fim [FFT];

  int exp_idx_q[$];
  int exp_mag_q[$];
  int acc_q[$];
  int last_idx = 0;
  int last_mag = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b, mx, mn;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
`ifdef PEAK_MAG_AMBM_EN
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
`else
    mx = 0;
    mn = 0;
    return a + b;
`endif
  endfunction

  // Expected result for the frame currently held in fre/fim.
  task automatic push_expect();
    int best, mx, m;
    best = 0;
    mx   = 0;
    for (int b = 1; b < int'(HFFT); b++) begin
      m = ref_mag(fre[b], fim[b]);
      if (m > mx) begin
        mx   = m;
        best = b;
      end
    end
    if (mx < int'(MAGFLOOR)) best = 0;
    exp_idx_q.push_back(best);
    exp_mag_q.push_back(mx);
    last_idx = best;
    last_mag = mx;
  endtask

  task automatic clear_frame();
    for (int b = 0; b < int'(FFT); b++) begin
      fre[b] = 0;
      fim[b] = 0;
    end
  endtask

  task automatic rand_frame(input int lim);
    for (int b = 0; b < int'(FFT); b++) begin
      fre[b] = int'($urandom_range(2 * lim)) - lim;
      fim[b] = int'($urandom_range(2 * lim)) - lim;
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic run_frame(input int n, input int gap_pct);
    for (int b = 0; b < n; b++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        i_valid = 1'b0;
        i_sop   = $urandom_range(1) == 1;
        @(negedge clk);
      end
      i_valid = 1'b1;
      i_sop   = (b == 0);
      i_re    = DW'(fre[b]);
      i_im    = DW'(fim[b]);
      if (b == int'(FFT) - 1) acc_q.push_back(cyc + 1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_sop   = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (8) @(negedge clk);
    check_eq({tag, "_pending"}, exp_idx_q.size(), 0);
    check_eq({tag, "_held_idx"}, o_index, last_idx);
    check_eq({tag, "_held_mag"}, o_mag, last_mag);
    check_eq({tag, "_valid_low"}, o_valid, 0);
    exp_idx_q.delete();
    exp_mag_q.delete();
    acc_q.delete();
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_idx_q.size() == 0) begin
        check_eq("spurious_valid", 1, 0);
      end else begin
        check_eq("index", o_index, exp_idx_q.pop_front());
        check_eq("mag", o_mag, exp_mag_q.pop_front());
        if (acc_q.size() != 0) check_eq("latency", cyc - acc_q.pop_front(), 3);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_re    = '0;
    i_im    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_idx", o_index, 0);
    check_eq("rst_mag", o_mag, 0);
    check_eq("rst_valid", o_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Tone at bin 37
    clear_frame();
    fre[37] = 1000;
    push_expect();
    run_frame(FFT, 0);
    drain("tone");

    // Tie: lowest index wins
    clear_frame();
    fre[20] = 500;  fim[20] = -500;
    fre[300] = 500; fim[300] = -500;
    push_expect();
    run_frame(FFT, 0);
    drain("tie");

    // DC and negative-frequency bins are excluded
    clear_frame();
    fre[0] = 30000; fre[700] = 30000; fre[5] = 200;
    push_expect();
    run_frame(FFT, 0);
    drain("excl");

    // Silence: candidates below the floor, loud excluded bins
    rand_frame(20);
    fre[0] = 32767;
    for (int b = int'(HFFT); b < int'(FFT); b++) fre[b] = int'($urandom_range(30000));
    push_expect();
    run_frame(FFT, 0);
    drain("silence");

    // Extremes
    clear_frame();
    fre[9] = -32768; fim[9] = -32768;
    push_expect();
    run_frame(FFT, 0);
    drain("extreme");

    // Resync: partial frame abandoned by a new sop
    rand_frame(30000);
    run_frame(400, 0);
    clear_frame();
    fre[100] = 4000; fim[100] = 123;
    push_expect();
    run_frame(FFT, 0);
    drain("resync");

    // Reset mid-frame; rst wins over a concurrent beat
    rand_frame(30000);
    run_frame(300, 10);
    rst = 1'b1; i_valid = 1'b1; i_sop = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0; i_sop = 1'b0;
    check_eq("midrst_idx", o_index, 0);
    check_eq("midrst_mag", o_mag, 0);
    last_idx = 0;
    last_mag = 0;
    drain("midrst");
    rand_frame(2000);
    fre[77] = 9000;
    push_expect();
    run_frame(FFT, 0);
    drain("postrst");

    // Random gaps, peak at bin 255
    rand_frame(1000);
    fre[255] = -20000; fim[255] = 7000;
    push_expect();
    run_frame(FFT, 30);
    drain("gaps");

    // Back-to-back full-range random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      rand_frame(32767);
      if (f == 1) begin
        fre[3] = -32768;
        fim[3] = -32768;
      end
      push_expect();
      run_frame(FFT, (f == 2) ? 0 : 15);
    end
    drain("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_peak_picker.md
Name: fft_peak_picker

Overview:
- Streaming stage directly upstream of the threshold block.
- Consumes the complex FFT output one bin per accepted beat and computes a magnitude approximation per bin.
- Tracks the strongest bin in the positive-frequency half, excluding DC.
- At the end of each frame, publishes that bin's index as a held level; this is the threshold block's i_data.

Parameters:
FFT, 1024, points per frame (power of two)
LGFFT, 10, log2(FFT)
HFFT, FFT/2, number of positive-frequency bins considered
DW, 16, signed width of each real/imag input sample
MAGFLOOR, 64, minimum peak magnitude; a frame peak below it reports index 0 (silence)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_valid  input  1  input beat valid; gaps between beats allowed
i_sop  input  1  first bin of a frame; qualified by i_valid
i_re  input  DW  signed real part
i_im  input  DW  signed imaginary part
o_index  output  LGFFT-1  peak bin index of last completed frame; held between frames
o_mag  output  DW+1  unsigned magnitude of that peak
o_valid  output  1  one-cycle pulse when o_index/o_mag update

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - o_index=0, o_mag=0, o_valid=0.
  - Bin counter=0, running max=0, best index=0, pipeline valids cleared.
  - rst wins over any simultaneous input beat; an in-progress frame is discarded.
- Bin counter (LGFFT bits):
  - Advances by one per accepted beat (i_valid=1).
  - A beat with i_sop=1 is bin 0, regardless of the counter value.
  - A beat with i_sop=1 arriving mid-frame abandons the partial frame: no o_valid, running max cleared, and the new beat counts as bin 0.
  - The counter wraps from FFT-1 to 0. The beat at bin FFT-1 ends the frame.
- Pipeline:
  - Stage 1 registers |re| and |im| as DW-bit unsigned. |-2^(DW-1)| = 2^(DW-1) fits without overflow.
  - Stage 2 registers mag = |re| + |im|, DW+1 bits, never saturates.
  - Stage 3 compare/update: only bins 1..HFFT-1 are candidates; bin 0 and bins >= HFFT never update the max.
  - Update only when mag > running max (strict), so on ties the lowest index wins.
- Frame end:
  - o_valid pulses high for exactly one cycle, 3 clk edges after the edge that accepts bin FFT-1.
  - If the final max >= MAGFLOOR, o_index=best index and o_mag=max.
  - Otherwise o_index=0 and o_mag=max.
  - The running max and best index clear for the next frame in the same cycle. A bin-1 beat of the next frame following back-to-back is not lost.
- o_index and o_mag change only on an o_valid cycle or on reset.
- Input bubbles (i_valid=0) do not change frame results; pipeline valid bits travel with the data.

Optional Feature:
- Macro: PEAK_MAG_AMBM_EN.
- Defined: stage 2 uses the alpha-max-beta-min approximation mag = max + (min>>2) + (min>>3), where max/min are taken over |re| and |im|.
  - Width stays DW+1.
  - Latency unchanged at 3.
- Undefined: mag = |re| + |im| as above.

Decomposition:
- Package fft_pkg holds:
  - FFT, LGFFT, HFFT, DW constants.
  - typedef bin_t = logic [LGFFT-2:0].
  - typedef mag_t = logic [DW:0].
  - typedef sample_t = logic signed [DW-1:0].
- Threshold, FFT and this block share the package.
- One sub-module, fft_mag_approx:
  - Stages 1-2: abs and magnitude, including the PEAK_MAG_AMBM_EN choice.
  - Carries the valid bit and bin index alongside the data.
- The top level holds the counter, compare/track logic and output registers.

Test Plan:
- Tone at bin 37: re=1000 at bin 37, all other bins 0, sop at bin 0 → one o_valid pulse 3 cycles after bin 1023; o_index=37, o_mag=1000 (AMBM: 1000).
- Tie: bins 20 and 300 both re=500, im=-500 → o_index=20, o_mag=1000 (AMBM: 687).
- Excluded bins: bin 0 re=30000, bin 700 re=30000, bin 5 re=200 → o_index=5. With all candidate bins below 64 → o_index=0.
- Extremes: bin 9 with re=-32768, im=-32768 → o_mag=65536 (17 bits), o_index=9, no overflow.
- Resync: sop at bin 0, 400 beats, then sop again followed by a full frame with peak at bin 100 → exactly one o_valid; o_index=100.
- Disruptions:
  - rst for one cycle mid-frame → outputs 0, no o_valid until a full frame completes.
  - Random i_valid gaps on a frame with peak at bin 255 → o_index=255.
